thread_scheduler: RTL and testbench
===================================

# thread_scheduler

- Per-cycle fetch-thread selector for the multithreaded core; replaces the fixed thread toggle in the fetch stage.
- Tracks a per-thread run state. Each cycle it grants one eligible thread round-robin and registers the grant for the fetch stage and context manager.
- Suspends a thread for a programmable penalty after a taken branch, and retires threads on halt.

## Interface
- NUM_THREADS, 4, number of hardware contexts (2..8)
- FLUSH_CYCLES, 2, cycles a thread is ineligible after a taken branch (0..15)
- TID_W, $clog2(NUM_THREADS), thread-id width (derived, not overridden)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- thread_en  in  NUM_THREADS  per-thread enable (level)
- stall_mask  in  NUM_THREADS  per-thread external hazard; set bit = not eligible this cycle, state unchanged
- branch_taken  in  1  taken-branch event from EX/WB
- branch_thread_id  in  TID_W  thread owning the branch
- halt_valid  in  1  halt event from EX/WB
- halt_thread_id  in  TID_W  thread owning the halt
- fetch_valid  out  1  registered; a thread is granted this cycle
- fetch_thread_id  out  TID_W  registered granted thread; holds last value when fetch_valid=0
- active_mask  out  NUM_THREADS  registered; bit set when thread state is RUN or FLUSH

## Operation
- Per-thread state: IDLE, RUN, FLUSH, HALT.
- Transition priority, highest first: rst, thread_en low, halt, branch, counter.
  - Any state with thread_en[t]=0: next state IDLE, flush counter cleared.
  - IDLE with thread_en[t]=1: next state RUN.
  - RUN with halt_valid for t: next state HALT. Halt beats branch in the same cycle.
  - RUN with branch_taken for t: if FLUSH_CYCLES>0, next state FLUSH and counter loads FLUSH_CYCLES. If FLUSH_CYCLES=0, thread stays RUN.
  - FLUSH: counter decrements each cycle; at counter==1 next state RUN. halt_valid in FLUSH goes to HALT. branch_taken in FLUSH is ignored.
  - HALT: leaves only via thread_en low, then IDLE.
- Events for threads in IDLE or HALT are ignored.
- Eligible[t] = (state==RUN) & ~stall_mask[t] & ~(branch_taken & branch_thread_id==t) & ~(halt_valid & halt_thread_id==t).
- Round-robin search starts at last_grant+1 modulo NUM_THREADS. The first eligible thread wins.
- last_grant updates only on a grant.
- No eligible thread: fetch_valid=0 and last_grant is unchanged.
- Flush counter width is 4 bits. Arithmetic is unsigned and never wraps below 0.

## Timing
- Decision uses cycle N state and inputs; fetch_valid and fetch_thread_id are visible after edge N+1 (1-cycle latency).
- A branch at cycle N makes thread t ineligible in grants for cycles N+1 .. N+FLUSH_CYCLES+1. Its first possible grant is at N+FLUSH_CYCLES+2.
- thread_en rising at cycle N: state RUN after edge N+1, first grant at N+2 at earliest.
- Reset values:
  - All states IDLE, counters 0.
  - fetch_valid=0, fetch_thread_id=0, active_mask=0.
  - last_grant=NUM_THREADS-1, so thread 0 has first priority.
- Reset mid-operation discards all state in one cycle; no grant in the cycle after reset.
- Single enabled thread with no stalls is granted every cycle. The scheduler inserts no bubbles.

## Configuration
- SCHED_PERF_CNT_EN defined:
  - Adds output issue_count (NUM_THREADS*32, packed, thread 0 in LSBs), incremented on each grant of the thread.
  - Adds output idle_cycles (32), incremented on each cycle with fetch_valid=0 after reset.
  - Both counters clear on rst and wrap at 2^32.
- Undefined: neither the ports nor the counters exist. Scheduling behaviour is identical either way.

## Structure
- defines.v gains:
  - State encodings: `TS_IDLE 2'd0, `TS_RUN 2'd1, `TS_FLUSH 2'd2, `TS_HALT 2'd3.
  - `TS_CNT_W 4.
- One sub-module, rr_arbiter: a combinational NUM_THREADS-wide round-robin picker.
  - Inputs: eligible mask, last_grant.
  - Outputs: grant_valid, grant_id.
- The state machines, flush counters and output registers stay in thread_scheduler.

## Test plan
- Reset, then thread_en=4'b1111, no events -> grants 0,1,2,3,0,... from the second cycle after enable, fetch_valid continuous.
- thread_en=4'b0101, stall_mask=4'b0100 for 3 cycles -> only thread 0 granted during the stall; alternation 0,2 resumes the cycle after the stall clears.
- FLUSH_CYCLES=2, branch_taken on thread 1 at cycle N -> thread 1 absent from grants N+1..N+3, eligible again N+4; other threads are unaffected.
- halt_valid and branch_taken for thread 2 in the same cycle -> thread 2 goes to HALT, never granted. active_mask bit 2 clears. Toggling thread_en[2] low then high restores RUN.
- All threads stalled -> fetch_valid=0 and fetch_thread_id holds. rst asserted mid-run -> next cycle all outputs 0, first grant after re-enable is thread 0.
- With SCHED_PERF_CNT_EN, 4 threads running 100 cycles -> each issue_count==25 (±1 at boundary), idle_cycles equals the count of startup bubble cycles.

Source files
------------

// File: rtl/thread_scheduler_pkg.sv
// Shared types and constants for the fetch-thread scheduler.
package thread_scheduler_pkg;

    // Per-thread run state; encodings match the fetch/context-manager view.
    typedef enum logic [1:0] {
        TS_IDLE  = 2'd0,
        TS_RUN   = 2'd1,
        TS_FLUSH = 2'd2,
        TS_HALT  = 2'd3
    } ts_state_e;

    // Width of the per-thread post-branch flush counter.
    localparam int unsigned TS_CNT_W = 4;

endpackage

// File: rtl/thread_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first eligible thread after last_grant wins.
module rr_arbiter #(
    parameter int unsigned NUM_THREADS = 4,
    localparam int unsigned TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic [NUM_THREADS-1:0] eligible,
    input  logic [TID_W-1:0]       last_grant,
    output logic                   grant_valid,
    output logic [TID_W-1:0]       grant_id
);

    logic [TID_W-1:0] idx;

    // Walk the ring starting one past the previous winner.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = '0;
        for (int unsigned i = 1; i <= NUM_THREADS; i++) begin
            idx = TID_W'((32'(last_grant) + i) % NUM_THREADS);
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_id    = idx;
            end
        end
    end

endmodule

// File: rtl/thread_scheduler.sv
// Per-cycle fetch-thread selector with post-branch flush and halt retirement.
// Optional macro SCHED_PERF_CNT_EN adds issue_count / idle_cycles counters.
module thread_scheduler
    import thread_scheduler_pkg::*;
#(
    parameter int unsigned NUM_THREADS  = 4,
    parameter int unsigned FLUSH_CYCLES = 2,
    localparam int unsigned TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_THREADS-1:0] thread_en,
    input  logic [NUM_THREADS-1:0] stall_mask,
    input  logic                   branch_taken,
    input  logic [TID_W-1:0]       branch_thread_id,
    input  logic                   halt_valid,
    input  logic [TID_W-1:0]       halt_thread_id,
    output logic                   fetch_valid,
    output logic [TID_W-1:0]       fetch_thread_id,
    output logic [NUM_THREADS-1:0] active_mask
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [NUM_THREADS*32-1:0] issue_count,
    output logic [31:0]               idle_cycles
`endif
);

    ts_state_e             state_q [NUM_THREADS];
    ts_state_e             state_d [NUM_THREADS];
    logic [TS_CNT_W-1:0]   cnt_q   [NUM_THREADS];
    logic [TS_CNT_W-1:0]   cnt_d   [NUM_THREADS];
    logic [NUM_THREADS-1:0] br_hit;
    logic [NUM_THREADS-1:0] halt_hit;
    logic [NUM_THREADS-1:0] eligible;
    logic [NUM_THREADS-1:0] active_d;
    logic [TID_W-1:0]       last_grant_q;
    logic                   grant_valid;
    logic [TID_W-1:0]       grant_id;

    // Next-state, flush counters and eligibility for every thread.
    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            state_d[t]  = state_q[t];
            cnt_d[t]    = cnt_q[t];
            br_hit[t]   = branch_taken && (branch_thread_id == TID_W'(t));
            halt_hit[t] = halt_valid && (halt_thread_id == TID_W'(t));

            if (!thread_en[t]) begin
                state_d[t] = TS_IDLE;
                cnt_d[t]   = '0;
            end else begin
                case (state_q[t])
                    TS_IDLE: state_d[t] = TS_RUN;
                    TS_RUN: begin
                        if (halt_hit[t]) begin
                            state_d[t] = TS_HALT;
                        end else if (br_hit[t] && (FLUSH_CYCLES != 0)) begin
                            state_d[t] = TS_FLUSH;
                            cnt_d[t]   = TS_CNT_W'(FLUSH_CYCLES);
                        end
                    end
                    TS_FLUSH: begin
                        if (halt_hit[t]) begin
                            state_d[t] = TS_HALT;
                            cnt_d[t]   = '0;
                        end else if (cnt_q[t] <= TS_CNT_W'(1)) begin
                            state_d[t] = TS_RUN;
                            cnt_d[t]   = '0;
                        end else begin
                            cnt_d[t]   = cnt_q[t] - TS_CNT_W'(1);
                        end
                    end
                    default: state_d[t] = TS_HALT;
                endcase
            end

            eligible[t] = (state_q[t] == TS_RUN) && !stall_mask[t] && !br_hit[t] && !halt_hit[t];
            active_d[t] = (state_d[t] == TS_RUN) || (state_d[t] == TS_FLUSH);
        end
    end

    rr_arbiter #(
        .NUM_THREADS (NUM_THREADS)
    ) u_rr_arbiter (
        .eligible    (eligible),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Thread state, counters, grant pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                state_q[t] <= TS_IDLE;
                cnt_q[t]   <= '0;
            end
            last_grant_q    <= TID_W'(NUM_THREADS - 1);
            fetch_valid     <= 1'b0;
            fetch_thread_id <= '0;
            active_mask     <= '0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                state_q[t] <= state_d[t];
                cnt_q[t]   <= cnt_d[t];
            end
            fetch_valid <= grant_valid;
            if (grant_valid) begin
                last_grant_q    <= grant_id;
                fetch_thread_id <= grant_id;
            end
            active_mask <= active_d;
        end
    end

`ifdef SCHED_PERF_CNT_EN
    // Per-thread issue counts and bubble-cycle count, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_count <= '0;
            idle_cycles <= '0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (grant_valid && (grant_id == TID_W'(t))) begin
                    issue_count[t*32 +: 32] <= issue_count[t*32 +: 32] + 32'd1;
                end
            end
            if (!fetch_valid) begin
                idle_cycles <= idle_cycles + 32'd1;
            end
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_thread_scheduler.sv
// Self-checking bench for thread_scheduler (NUM_THREADS=4, FLUSH_CYCLES=2).
module tb_thread_scheduler;

    localparam int unsigned NT    = 4;
    localparam int unsigned FLUSH = 2;
    localparam int unsigned TW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NT-1:0] thread_en;
    logic [NT-1:0] stall_mask;
    logic          branch_taken;
    logic [TW-1:0] branch_thread_id;
    logic          halt_valid;
    logic [TW-1:0] halt_thread_id;
    logic          fetch_valid;
    logic [TW-1:0] fetch_thread_id;
    logic [NT-1:0] active_mask;
`ifdef SCHED_PERF_CNT_EN
    logic [NT*32-1:0] issue_count;
    logic [31:0]      idle_cycles;
`endif

    thread_scheduler #(
        .NUM_THREADS  (NT),
        .FLUSH_CYCLES (FLUSH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .thread_en        (thread_en),
        .stall_mask       (stall_mask),
        .branch_taken     (branch_taken),
        .branch_thread_id (branch_thread_id),
        .halt_valid       (halt_valid),
        .halt_thread_id   (halt_thread_id),
        .fetch_valid      (fetch_valid),
        .fetch_thread_id  (fetch_thread_id),
        .active_mask      (active_mask)
`ifdef SCHED_PERF_CNT_EN
        ,
        .issue_count      (issue_count),
        .idle_cycles      (idle_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [NT-1:0] en;
        logic [NT-1:0] stall;
        logic          br;
        logic [TW-1:0] bid;
        logic          hlt;
        logic [TW-1:0] hid;
        logic          ev;
        logic [TW-1:0] eid;
        logic [NT-1:0] eam;
    } vec_t;

    typedef struct {
        logic          ev;
        logic [TW-1:0] eid;
        logic [NT-1:0] eam;
        int            row;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic r, input logic [NT-1:0] en, input logic [NT-1:0] st,
                                input logic br, input logic [TW-1:0] bid,
                                input logic h, input logic [TW-1:0] hid,
                                input logic ev, input logic [TW-1:0] eid, input logic [NT-1:0] eam);
        vec_t x;
        x.rst = r; x.en = en; x.stall = st; x.br = br; x.bid = bid;
        x.hlt = h; x.hid = hid; x.ev = ev; x.eid = eid; x.eam = eam;
        return x;
    endfunction

    task automatic check(input string name, input int row, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%0h exp=%0h", name, row, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [NT-1:0] en, input logic [NT-1:0] st,
                         input logic br, input logic [TW-1:0] bid,
                         input logic h, input logic [TW-1:0] hid);
        rst = r; thread_en = en; stall_mask = st;
        branch_taken = br; branch_thread_id = bid;
        halt_valid = h; halt_thread_id = hid;
    endtask

    initial begin
        int   k;
        exp_t e;
        drive(1'b1, '0, '0, 1'b0, '0, 1'b0, '0);

        // rst en stall br bid h hid | valid id active
        vecs.push_back(mk(1, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0)); // 1 reset
        vecs.push_back(mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 0, 0, 4'hF)); // 2 enable, no grant yet
        vecs.push_back(mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 1, 0, 4'hF)); // 3
        vecs.push_back(mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 1, 1, 4'hF)); // 4
        vecs.push_back(mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 1, 2, 4'hF)); // 5
        vecs.push_back(mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 1, 3, 4'hF)); // 6
        vecs.push_back(mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 1, 0, 4'hF)); // 7
        vecs.push_back(mk(0, 4'hF, 4'h0, 1, 1, 0, 0, 1, 2, 4'hF)); // 8 branch t1
        vecs.push_back(mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 1, 3, 4'hF)); // 9
        vecs.push_back(mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 1, 0, 4'hF)); // 10
        vecs.push_back(mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 1, 1, 4'hF)); // 11 t1 back
        vecs.push_back(mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 1, 2, 4'hF)); // 12
        vecs.push_back(mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 1, 3, 4'hF)); // 13
        vecs.push_back(mk(0, 4'hF, 4'h0, 1, 2, 1, 2, 1, 0, 4'hB)); // 14 halt+branch t2
        vecs.push_back(mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 1, 1, 4'hB)); // 15
        vecs.push_back(mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 1, 3, 4'hB)); // 16 t2 skipped
        vecs.push_back(mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 1, 0, 4'hB)); // 17
        vecs.push_back(mk(0, 4'hB, 4'h0, 0, 0, 0, 0, 1, 1, 4'hB)); // 18 t2 en low
        vecs.push_back(mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 1, 3, 4'hF)); // 19 t2 idle->run
        vecs.push_back(mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 1, 0, 4'hF)); // 20
        vecs.push_back(mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 1, 1, 4'hF)); // 21
        vecs.push_back(mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 1, 2, 4'hF)); // 22 t2 restored
        vecs.push_back(mk(0, 4'hF, 4'hF, 0, 0, 0, 0, 0, 2, 4'hF)); // 23 all stalled, id holds
        vecs.push_back(mk(0, 4'hF, 4'hF, 0, 0, 0, 0, 0, 2, 4'hF)); // 24
        vecs.push_back(mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 1, 3, 4'hF)); // 25
        vecs.push_back(mk(1, 4'hF, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0)); // 26 mid-run reset
        vecs.push_back(mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 0, 0, 4'hF)); // 27
        vecs.push_back(mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 1, 0, 4'hF)); // 28 thread 0 first
        vecs.push_back(mk(0, 4'h5, 4'h0, 0, 0, 0, 0, 1, 1, 4'h5)); // 29 t1 still RUN this cycle
        vecs.push_back(mk(0, 4'h5, 4'h4, 0, 0, 0, 0, 1, 0, 4'h5)); // 30 t2 stalled
        vecs.push_back(mk(0, 4'h5, 4'h4, 0, 0, 0, 0, 1, 0, 4'h5)); // 31
        vecs.push_back(mk(0, 4'h5, 4'h4, 0, 0, 0, 0, 1, 0, 4'h5)); // 32
        vecs.push_back(mk(0, 4'h5, 4'h0, 0, 0, 0, 0, 1, 2, 4'h5)); // 33 alternation resumes
        vecs.push_back(mk(0, 4'h5, 4'h0, 0, 0, 0, 0, 1, 0, 4'h5)); // 34
        vecs.push_back(mk(0, 4'h5, 4'h0, 0, 0, 0, 0, 1, 2, 4'h5)); // 35
        vecs.push_back(mk(0, 4'h5, 4'h0, 1, 0, 0, 0, 1, 2, 4'h5)); // 36 branch t0
        vecs.push_back(mk(0, 4'h5, 4'h0, 0, 0, 1, 0, 1, 2, 4'h4)); // 37 halt t0 in FLUSH
        vecs.push_back(mk(0, 4'h5, 4'h0, 0, 0, 0, 0, 1, 2, 4'h4)); // 38
        vecs.push_back(mk(0, 4'h4, 4'h0, 0, 0, 0, 0, 1, 2, 4'h4)); // 39 single thread
        vecs.push_back(mk(0, 4'h4, 4'h0, 0, 0, 0, 0, 1, 2, 4'h4)); // 40
        vecs.push_back(mk(0, 4'h4, 4'h0, 0, 0, 0, 0, 1, 2, 4'h4)); // 41

        // Table: expectations queued at drive time, retired after the edge.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].stall, vecs[i].br, vecs[i].bid,
                  vecs[i].hlt, vecs[i].hid);
            e.ev = vecs[i].ev; e.eid = vecs[i].eid; e.eam = vecs[i].eam; e.row = i + 1;
            sb.push_back(e);
            tick();
            if (sb.size() == 0) begin
                check("scoreboard_empty", i + 1, 0, 1);
            end else begin
                e = sb.pop_front();
                check("fetch_valid", e.row, int'(fetch_valid), int'(e.ev));
                check("fetch_thread_id", e.row, int'(fetch_thread_id), int'(e.eid));
                check("active_mask", e.row, int'(active_mask), int'(e.eam));
            end
        end

        // Hand sequence: single thread 1, no bubbles, then branch flush window.
        drive(1'b0, 4'h2, 4'h0, 1'b0, '0, 1'b0, '0);
        k = 0;
        tick();
        while (!(fetch_valid && fetch_thread_id == 2'd1) && k < 10) begin
            tick();
            k++;
        end
        check("t1_start_timeout", 0, int'(k < 10), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_no_bubble_valid", i, int'(fetch_valid), 1);
            check("t1_no_bubble_id", i, int'(fetch_thread_id), 1);
        end
        drive(1'b0, 4'h2, 4'h0, 1'b1, 2'd1, 1'b0, '0);
        tick();
        branch_taken = 1'b0;
        k = 1;
        while (!fetch_valid && k < 20) begin
            check("flush_id_hold", k, int'(fetch_thread_id), 1);
            tick();
            k++;
        end
        check("flush_regrant_latency", 0, k, int'(FLUSH) + 2);
        check("flush_regrant_id", 0, int'(fetch_thread_id), 1);

`ifdef SCHED_PERF_CNT_EN
        // Perf counters: 4 threads, 102 cycles after reset -> 100 grants, 2 bubbles.
        drive(1'b1, 4'h0, 4'h0, 1'b0, '0, 1'b0, '0);
        tick();
        thread_en = 4'hF;
        rst = 1'b0;
        for (int i = 0; i < 102; i++) tick();
        for (int t = 0; t < NT; t++) begin
            check("issue_count_lo", t, int'(issue_count[t*32 +: 32] >= 32'd24), 1);
            check("issue_count_hi", t, int'(issue_count[t*32 +: 32] <= 32'd26), 1);
        end
        check("idle_cycles", 0, int'(idle_cycles), 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
